// File: rtl/mem_access_unit_pkg.sv
// Shared MEM-stage definitions: DMType encodings, FSM states, access-size decode.
package mem_access_unit_pkg;

    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } size_e;

    // Unknown encodings fall back to word so they are checked for word alignment.
    function automatic size_e dm_size(input logic [2:0] dm);
        case (dm)
            DM_HALF, DM_HALF_U: return SZ_HALF;
            DM_BYTE, DM_BYTE_U: return SZ_BYTE;
            default:            return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_WORD: return off != 2'b00;
            SZ_HALF: return off[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-bus request/ack channel between the MEM stage (master) and data memory (slave).
interface mem_access_unit_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_wstrb;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_wstrb, dbus_wdata,
        input  dbus_ack, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_wstrb, dbus_wdata,
        output dbus_ack, dbus_rdata
    );
endinterface

// File: rtl/mem_access_unit_load_formatter.sv
// Combinational load formatter: picks byte/half at the offset and extends per DMType.
module mem_access_unit_load_formatter
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  dm_type,
    output logic [31:0] result
);
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = rdata[{offset, 3'b000} +: 8];
        sel_half = offset[1] ? rdata[31:16] : rdata[15:0];
        case (dm_type)
            DM_HALF:   result = {{16{sel_half[15]}}, sel_half};
            DM_HALF_U: result = {16'h0000, sel_half};
            DM_BYTE:   result = {{24{sel_byte[7]}}, sel_byte};
            DM_BYTE_U: result = {24'h000000, sel_byte};
            default:   result = rdata;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: registered dbus request, min 2-cycle latency (REQ, RESP).
// Stalls the pipeline while an aligned access is in IDLE/REQ; aborts after TIMEOUT REQ cycles.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                me_aluOut_WB_memOut,
    input  logic                me_mem_w,
    input  logic [2:0]          me_DMType,
    input  logic [31:0]         me_outAlu,
    input  logic [31:0]         me_rs2Data,
    mem_access_unit_if.master   dbus,
    output logic                mem_stall,
    output logic [31:0]         mem_rdata,
    output logic                mem_misalign,
    output logic                mem_buserr
);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        off_q;
    logic [2:0]        dm_q;

    logic              store, load, access, misal, aligned_acc, misal_acc;
    size_e             sz;
    logic [3:0]        wstrb_n;
    logic [31:0]       wdata_n;
    logic              issue, done_ack, done_to;
    logic [31:0]       fmt_rdata;

    // Store wins when both flags are set.
    assign store       = me_mem_w;
    assign load        = me_aluOut_WB_memOut & ~me_mem_w;
    assign access      = load | store;
    assign sz          = dm_size(me_DMType);
    assign misal       = is_misaligned(sz, me_outAlu[1:0]);
    assign aligned_acc = access & ~misal;
    assign misal_acc   = access & misal;

    always_comb begin
        wstrb_n = 4'b0000;
        wdata_n = 32'h0;
        if (store) begin
            case (sz)
                SZ_BYTE: begin
                    wstrb_n = 4'b0001 << me_outAlu[1:0];
                    wdata_n = {4{me_rs2Data[7:0]}};
                end
                SZ_HALF: begin
                    wstrb_n = 4'b0011 << {me_outAlu[1], 1'b0};
                    wdata_n = {2{me_rs2Data[15:0]}};
                end
                default: begin
                    wstrb_n = 4'b1111;
                    wdata_n = me_rs2Data;
                end
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        issue     = 1'b0;
        done_ack  = 1'b0;
        done_to   = 1'b0;
        mem_stall = aligned_acc & (state_q != ST_RESP);
        case (state_q)
            ST_IDLE: begin
                if (aligned_acc) begin
                    issue   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (dbus.dbus_ack) begin
                    done_ack = 1'b1;
                    state_d  = ST_RESP;
                end else if (cnt_q == TO_LAST) begin
                    done_to = 1'b1;
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    mem_access_unit_load_formatter u_fmt (
        .rdata   (dbus.dbus_rdata),
        .offset  (off_q),
        .dm_type (dm_q),
        .result  (fmt_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q           <= '0;
            off_q           <= 2'b00;
            dm_q            <= DM_WORD;
            dbus.dbus_req   <= 1'b0;
            dbus.dbus_we    <= 1'b0;
            dbus.dbus_addr  <= 32'h0;
            dbus.dbus_wstrb <= 4'b0000;
            dbus.dbus_wdata <= 32'h0;
            mem_rdata       <= 32'h0;
            mem_misalign    <= 1'b0;
            mem_buserr      <= 1'b0;
        end else begin
            cnt_q        <= (state_q == ST_REQ) ? cnt_q + 1'b1 : '0;
            mem_misalign <= (state_q == ST_IDLE) & misal_acc;
            mem_buserr   <= done_to;

            if (issue) begin
                dbus.dbus_req   <= 1'b1;
                dbus.dbus_we    <= store;
                dbus.dbus_addr  <= {me_outAlu[31:2], 2'b00};
                dbus.dbus_wstrb <= wstrb_n;
                dbus.dbus_wdata <= wdata_n;
                off_q           <= me_outAlu[1:0];
                dm_q            <= me_DMType;
            end else if (done_ack | done_to) begin
                dbus.dbus_req <= 1'b0;
            end

            // Stores complete without touching the last load result.
            if (done_ack && !dbus.dbus_we) begin
                mem_rdata <= fmt_rdata;
            end else if (done_to || ((state_q == ST_IDLE) && misal_acc)) begin
                mem_rdata <= 32'h0;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed + randomized bench for mem_access_unit with an arithmetic reference model.
module tb_mem_access_unit;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld, st;
    logic [2:0]  dmt;
    logic [31:0] addr, rs2;
    logic        mem_stall, mem_misalign, mem_buserr;
    logic [31:0] mem_rdata;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_rdata = 32'h0;

    mem_access_unit_if dbus ();

    mem_access_unit #(.TIMEOUT(TO), .CNT_W(5)) dut (
        .clk                 (clk),
        .rst                 (rst_n),
        .me_aluOut_WB_memOut (ld),
        .me_mem_w            (st),
        .me_DMType           (dmt),
        .me_outAlu           (addr),
        .me_rs2Data          (rs2),
        .dbus                (dbus),
        .mem_stall           (mem_stall),
        .mem_rdata           (mem_rdata),
        .mem_misalign        (mem_misalign),
        .mem_buserr          (mem_buserr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] dm);
        if (dm == 3'd1 || dm == 3'd2) return 2;
        if (dm == 3'd3 || dm == 3'd4) return 1;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input int off, input logic [2:0] dm);
        int     sz;
        longint v;
        sz = size_of(dm);
        if (sz == 4) return w;
        v = (longint'(w) >> (8 * off)) & ((64'd1 << (8 * sz)) - 1);
        if ((dm == 3'd1 || dm == 3'd3) && v >= (64'd1 << (8 * sz - 1)))
            v = v - (64'd1 << (8 * sz));
        return v[31:0];
    endfunction

    // ack_dly: REQ cycle (0-based) in which ack is returned; >= TO means never.
    task automatic run_access(input logic l, input logic s, input logic [2:0] dm,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] rd, input int ack_dly);
        int          sz, off, n, exp_cycles;
        bit          acc, mis;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata, dw;
        sz  = size_of(dm);
        off = int'(a[1:0]);
        acc = l | s;
        mis = acc && (off % sz != 0);
        dw  = d;
        e_strb  = 4'b0;
        e_wdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + sz) e_strb[i] = 1'b1;
            e_wdata[8*i +: 8] = dw[8*(i % sz) +: 8];
        end

        @(posedge clk); #1;
        ld = l; st = s; dmt = dm; addr = a; rs2 = d;
        #1;
        chk("stall_at_issue", mem_stall, acc && !mis);
        if (!acc || mis) begin
            @(posedge clk); #1;
            chk("no_req", dbus.dbus_req, 1'b0);
            chk("misalign_flag", mem_misalign, mis);
            if (mis) exp_rdata = 32'h0;
            chk("rdata_after_noissue", mem_rdata, exp_rdata);
            ld = 0; st = 0;
            @(posedge clk); #1;
            chk("misalign_pulse_end", mem_misalign, 1'b0);
            return;
        end

        @(posedge clk); #1;
        chk("addr", dbus.dbus_addr, {a[31:2], 2'b00});
        chk("we", dbus.dbus_we, s);
        if (s) begin
            chk("wstrb", dbus.dbus_wstrb, e_strb);
            chk("wdata", dbus.dbus_wdata, e_wdata);
        end
        n = 0;
        while (dbus.dbus_req === 1'b1 && n < 40) begin
            chk("stall_in_req", mem_stall, 1'b1);
            if (n == ack_dly) begin
                dbus.dbus_ack = 1'b1; dbus.dbus_rdata = rd;
            end else begin
                dbus.dbus_ack = 1'b0; dbus.dbus_rdata = $urandom;
            end
            @(posedge clk); #1;
            n++;
        end
        dbus.dbus_ack = 1'b0;
        exp_cycles = (ack_dly < TO) ? ack_dly + 1 : TO;
        chk("req_cycles", n, exp_cycles);
        chk("stall_in_resp", mem_stall, 1'b0);
        chk("buserr", mem_buserr, ack_dly >= TO);
        if (ack_dly >= TO) exp_rdata = 32'h0;
        else if (!s) exp_rdata = model_load(rd, off, dm);
        chk("rdata", mem_rdata, exp_rdata);
        ld = 0; st = 0;
        @(posedge clk); #1;
        chk("buserr_pulse_end", mem_buserr, 1'b0);
        chk("req_idle", dbus.dbus_req, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; ld = 0; st = 0; dmt = 3'd0; addr = 0; rs2 = 0;
        dbus.dbus_ack = 1'b0; dbus.dbus_rdata = 32'h0;
        #12;
        chk("rst_req", dbus.dbus_req, 1'b0);
        chk("rst_addr", dbus.dbus_addr, 32'h0);
        chk("rst_wstrb", dbus.dbus_wstrb, 4'h0);
        chk("rst_wdata", dbus.dbus_wdata, 32'h0);
        chk("rst_rdata", mem_rdata, 32'h0);
        chk("rst_flags", {mem_misalign, mem_buserr, mem_stall}, 3'b000);
        @(negedge clk); rst_n = 1'b1;

        run_access(1, 0, 3'd0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        chk("lw_value", mem_rdata, 32'hDEADBEEF);
        run_access(1, 0, 3'd3, 32'h103, 32'h0, 32'h80FF1234, 1);
        chk("lb_value", mem_rdata, 32'hFFFFFF80);
        run_access(1, 0, 3'd4, 32'h103, 32'h0, 32'h80FF1234, 2);
        chk("lbu_value", mem_rdata, 32'h00000080);
        run_access(0, 1, 3'd1, 32'h202, 32'h0000ABCD, 32'h0, 0);
        chk("sh_keeps_rdata", mem_rdata, 32'h00000080);
        run_access(1, 0, 3'd2, 32'h402, 32'h0, 32'h9876F000, 3);
        run_access(1, 0, 3'd1, 32'h402, 32'h0, 32'h9876F000, 0);
        run_access(1, 0, 3'd7, 32'h500, 32'h0, 32'h13579BDF, 0);
        run_access(1, 1, 3'd0, 32'h604, 32'hCAFEF00D, 32'h11111111, 1);
        run_access(1, 0, 3'd0, 32'h101, 32'h0, 32'h0, 0);
        chk("misalign_rdata", mem_rdata, 32'h0);
        run_access(1, 0, 3'd0, 32'h700, 32'h0, 32'h0, 99);
        run_access(1, 0, 3'd0, 32'h704, 32'h0, 32'h2468ACE0, 15);

        // Ack while idle must not disturb anything.
        @(posedge clk); #1;
        dbus.dbus_ack = 1'b1; dbus.dbus_rdata = 32'h55AA55AA;
        @(posedge clk); #1;
        dbus.dbus_ack = 1'b0;
        chk("idle_ack_req", dbus.dbus_req, 1'b0);
        chk("idle_ack_rdata", mem_rdata, exp_rdata);

        // Async reset in the middle of REQ.
        @(posedge clk); #1;
        ld = 1; st = 0; dmt = 3'd0; addr = 32'h300;
        @(posedge clk); #1;
        chk("pre_rst_req", dbus.dbus_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", dbus.dbus_req, 1'b0);
        chk("arst_addr", dbus.dbus_addr, 32'h0);
        chk("arst_rdata", mem_rdata, 32'h0);
        chk("arst_flags", {dbus.dbus_we, dbus.dbus_wstrb, mem_misalign, mem_buserr}, 7'h0);
        ld = 0;
        exp_rdata = 32'h0;
        @(negedge clk); rst_n = 1'b1;
        run_access(1, 0, 3'd0, 32'h800, 32'h0, 32'h0BADCAFE, 0);

        for (int k = 0; k < 60; k++) begin
            logic       rl, rs;
            logic [2:0] rdm;
            int         dly;
            rl  = 1'($urandom_range(0, 1));
            rs  = 1'($urandom_range(0, 1));
            rdm = 3'($urandom_range(0, 7));
            dly = ($urandom_range(0, 9) == 0) ? 30 : $urandom_range(0, 5);
            run_access(rl, rs, rdm, $urandom, $urandom, $urandom, dly);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
